// File: rtl/metaballs_pkg.sv
// Shared types and screen constants for the metaball motion block.
// Also holds the per-ball start-position helper.
package metaballs_pkg;

  localparam int SCREEN_WIDTH  = 800;
  localparam int SCREEN_HEIGHT = 600;
  localparam int BALL_DIM      = 25;
  localparam int MAX_BALLS     = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    UPD_X = 2'd1,
    UPD_Y = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Staggered start so balls begin apart and on the speed grid.
  function automatic logic [9:0] start_pos(
    input int   i,
    input logic axis,
    input int   speed
  );
    int v;
    v = axis ? speed * (4 + 10 * i) : speed * (6 + 8 * i);
    return v[9:0];
  endfunction

endpackage

// File: rtl/axis_step.sv
// One-axis position step with edge bounce.
// Shared between the x and y updates of every ball.
module axis_step (
  input  logic [9:0] i_pos,
  input  logic       i_dir,
  input  logic [9:0] i_limit,
  input  logic [9:0] i_speed,
  output logic [9:0] o_pos_next,
  output logic       o_dir_next
);

  logic [9:0] w_turn_hi;

  assign w_turn_hi = i_limit - i_speed;

  // Move with the old direction; flip one step before either edge.
  always_comb begin
    o_pos_next = i_dir ? (i_pos + i_speed) : (i_pos - i_speed);
    o_dir_next = i_dir;
    if (i_pos == i_speed)
      o_dir_next = 1'b1;
    else if (i_pos == w_turn_hi)
      o_dir_next = 1'b0;
  end

endmodule

// File: rtl/ball_motion_sequencer.sv
// Per-frame ball motion sweep through one shared axis stepper.
// Triggered by the falling edge of v_sync; read port is combinational.
module ball_motion_sequencer #(
  parameter int NUM_BALLS     = 4,
  parameter int BALL_SPEED    = 5,
  parameter int SCREEN_WIDTH  = metaballs_pkg::SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT = metaballs_pkg::SCREEN_HEIGHT,
  parameter int BALL_DIM      = metaballs_pkg::BALL_DIM
) (
  input  logic        clk_100mhz,
  input  logic        reset,
  input  logic        v_sync,
  input  logic        pause,
  input  logic [2:0]  rd_idx,
  output logic [9:0]  rd_x,
  output logic [9:0]  rd_y,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_count
);

  import metaballs_pkg::*;

  localparam logic [9:0] SPD   = 10'(BALL_SPEED);
  localparam logic [9:0] LIM_X = 10'(SCREEN_WIDTH - BALL_DIM);
  localparam logic [9:0] LIM_Y = 10'(SCREEN_HEIGHT - BALL_DIM);
  localparam logic [2:0] LAST  = 3'(NUM_BALLS - 1);
  localparam logic [3:0] NB4   = 4'(NUM_BALLS);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_vs_q;
  logic [2:0]  r_idx;
  logic [15:0] r_frame_count;
  logic [9:0]  r_x  [MAX_BALLS];
  logic [9:0]  r_y  [MAX_BALLS];
  logic        r_vx [MAX_BALLS];
  logic        r_vy [MAX_BALLS];

  logic        w_start;
  logic        w_last;
  logic        w_sel_y;
  logic [9:0]  w_pos;
  logic        w_dir;
  logic [9:0]  w_limit;
  logic [9:0]  w_pos_nxt;
  logic        w_dir_nxt;

  assign w_start = r_vs_q & ~v_sync & ~pause & (r_state == IDLE);
  assign w_last  = (r_idx == LAST);
  assign w_sel_y = (r_state == UPD_Y);

  assign w_pos   = w_sel_y ? r_y[r_idx]  : r_x[r_idx];
  assign w_dir   = w_sel_y ? r_vy[r_idx] : r_vx[r_idx];
  assign w_limit = w_sel_y ? LIM_Y       : LIM_X;

  axis_step u_step (
    .i_pos      (w_pos),
    .i_dir      (w_dir),
    .i_limit    (w_limit),
    .i_speed    (SPD),
    .o_pos_next (w_pos_nxt),
    .o_dir_next (w_dir_nxt)
  );

  // State register.
  always_ff @(posedge clk_100mhz) begin
    if (reset)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  // Sweep sequencing: x then y for each ball, then one DONE cycle.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_start) w_state_nxt = UPD_X;
      UPD_X:   w_state_nxt = UPD_Y;
      UPD_Y:   w_state_nxt = w_last ? DONE : UPD_X;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Ball state, edge detect, index and frame counter.
  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      r_vs_q        <= 1'b1;
      r_idx         <= 3'd0;
      r_frame_count <= 16'd0;
      for (int i = 0; i < MAX_BALLS; i++) begin
        r_x[i]  <= start_pos(i, 1'b0, BALL_SPEED);
        r_y[i]  <= start_pos(i, 1'b1, BALL_SPEED);
        r_vx[i] <= 1'b1;
        r_vy[i] <= 1'b1;
      end
    end else begin
      r_vs_q <= v_sync;
      if (w_start)
        r_idx <= 3'd0;
      if (r_state == UPD_X) begin
        r_x[r_idx]  <= w_pos_nxt;
        r_vx[r_idx] <= w_dir_nxt;
      end
      if (r_state == UPD_Y) begin
        r_y[r_idx]  <= w_pos_nxt;
        r_vy[r_idx] <= w_dir_nxt;
        r_idx       <= w_last ? 3'd0 : r_idx + 3'd1;
      end
      if (r_state == DONE)
        r_frame_count <= r_frame_count + 16'd1;
    end
  end

  // Read port; indices past the last ball read as zero.
  always_comb begin
    rd_x = 10'd0;
    rd_y = 10'd0;
    if ({1'b0, rd_idx} < NB4) begin
      rd_x = r_x[rd_idx];
      rd_y = r_y[rd_idx];
    end
  end

  assign busy        = (r_state == UPD_X) | (r_state == UPD_Y);
  assign frame_done  = (r_state == DONE);
  assign frame_count = r_frame_count;

endmodule

// File: tb/tb_ball_motion_sequencer.sv
// Self-checking bench for ball_motion_sequencer.
// Table of hand-derived positions plus a frame scoreboard.
module tb_ball_motion_sequencer;

  localparam int NB = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        v_sync = 1'b1;
  logic        pause = 1'b0;
  logic [2:0]  rd_idx = 3'd0;
  logic [9:0]  rd_x;
  logic [9:0]  rd_y;
  logic        busy;
  logic        frame_done;
  logic [15:0] frame_count;

  ball_motion_sequencer dut (
    .clk_100mhz  (clk),
    .reset       (reset),
    .v_sync      (v_sync),
    .pause       (pause),
    .rd_idx      (rd_idx),
    .rd_x        (rd_x),
    .rd_y        (rd_y),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_count (frame_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NB-1:0][9:0] x;
    logic [NB-1:0][9:0] y;
    logic [15:0]        fc;
  } exp_t;

  typedef struct {
    int frame;
    int idx;
    int x;
    int y;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int nfr = 0;
  int mx[NB], my[NB], mvx[NB], mvy[NB];
  int mfc;
  exp_t sb[$];
  vec_t tbl[13];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void mstep(inout int p, inout int d, input int lim);
    int np, nd;
    np = d ? p + 5 : p - 5;
    nd = (p == 5) ? 1 : (p == lim - 5) ? 0 : d;
    p = np;
    d = nd;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      mx[i] = 5 * (6 + 8 * i);
      my[i] = 5 * (4 + 10 * i);
      mvx[i] = 1;
      mvy[i] = 1;
    end
    mfc = 0;
  endtask

  function automatic exp_t model_snap();
    exp_t e;
    for (int i = 0; i < NB; i++) begin
      e.x[i] = 10'(mx[i]);
      e.y[i] = 10'(my[i]);
    end
    e.fc = 16'(mfc);
    return e;
  endfunction

  task automatic model_frame();
    for (int i = 0; i < NB; i++) begin
      mstep(mx[i], mvx[i], 775);
      mstep(my[i], mvy[i], 575);
    end
    mfc = (mfc + 1) & 16'hFFFF;
  endtask

  task automatic check_balls(input exp_t e);
    for (int i = 0; i < NB; i++) begin
      rd_idx = 3'(i);
      #1;
      chk($sformatf("ball%0d_x", i), int'(rd_x), int'(e.x[i]));
      chk($sformatf("ball%0d_y", i), int'(rd_y), int'(e.y[i]));
    end
  endtask

  task automatic do_frame();
    exp_t e;
    int busy_n, done_at;
    model_frame();
    sb.push_back(model_snap());
    @(negedge clk) v_sync = 1'b0;
    busy_n = 0;
    done_at = 0;
    for (int k = 1; k <= 40 && done_at == 0; k++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (frame_done) done_at = k;
    end
    chk("busy_cycles", busy_n, 2 * NB);
    chk("done_latency", done_at, 2 * NB + 1);
    if (done_at != 0 && sb.size() > 0) begin
      e = sb.pop_front();
      check_balls(e);
      @(negedge clk);
      chk("done_pulse_width", int'(frame_done), 0);
      chk("frame_count", int'(frame_count), int'(e.fc));
    end
    v_sync = 1'b1;
    @(negedge clk);
    nfr++;
  endtask

  initial begin
    exp_t e;
    int seen, pulses;

    tbl[0]  = '{0, 0, 30, 20};
    tbl[1]  = '{0, 3, 150, 170};
    tbl[2]  = '{1, 0, 35, 25};
    tbl[3]  = '{1, 3, 155, 175};
    tbl[4]  = '{110, 0, 580, 570};
    tbl[5]  = '{111, 0, 585, 575};
    tbl[6]  = '{112, 0, 590, 570};
    tbl[7]  = '{148, 0, 770, 390};
    tbl[8]  = '{149, 0, 775, 385};
    tbl[9]  = '{150, 0, 770, 380};
    tbl[10] = '{303, 0, 5, 385};
    tbl[11] = '{304, 0, 0, 390};
    tbl[12] = '{305, 0, 5, 395};

    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_frame_done", int'(frame_done), 0);
    chk("reset_frame_count", int'(frame_count), 0);
    check_balls(model_snap());

    foreach (tbl[t]) begin
      while (nfr < tbl[t].frame) do_frame();
      rd_idx = 3'(tbl[t].idx);
      #1;
      chk($sformatf("tbl%0d_x", t), int'(rd_x), tbl[t].x);
      chk($sformatf("tbl%0d_y", t), int'(rd_y), tbl[t].y);
    end

    pause = 1'b1;
    seen = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk) v_sync = 1'b0;
      repeat (12) begin
        @(negedge clk);
        if (busy || frame_done) seen++;
      end
      v_sync = 1'b1;
      @(negedge clk);
    end
    pause = 1'b0;
    chk("pause_no_sweep", seen, 0);
    check_balls(model_snap());
    chk("pause_frame_count", int'(frame_count), mfc);

    model_frame();
    sb.push_back(model_snap());
    pulses = 0;
    @(negedge clk) v_sync = 1'b0;
    repeat (1000) begin
      @(negedge clk);
      if (frame_done) begin
        pulses++;
        if (sb.size() > 0) begin
          e = sb.pop_front();
          check_balls(e);
        end
      end
    end
    v_sync = 1'b1;
    @(negedge clk);
    chk("hold_low_pulses", pulses, 1);
    chk("hold_low_frame_count", int'(frame_count), mfc);

    @(negedge clk) v_sync = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_sweep_busy", int'(busy), 1);
    reset = 1'b1;
    v_sync = 1'b1;
    @(negedge clk);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_frame_done", int'(frame_done), 0);
    chk("rst_mid_frame_count", int'(frame_count), 0);
    model_reset();
    check_balls(model_snap());
    rd_idx = 3'd5;
    #1;
    chk("rd_oob_x", int'(rd_x), 0);
    chk("rd_oob_y", int'(rd_y), 0);
    reset = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (frame_done || busy) seen++;
    end
    chk("rst_no_pulse", seen, 0);

    do_frame();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
